// File: rtl/cpu_result_uart_pkg.sv
// Shared types and constants for the CPU result UART reporter.
// CPU_RESULT_UART_SYNC_EN (optional) prefixes every frame with UR_SYNC_BYTE.
package cpu_result_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ur_state_t;

  localparam logic [7:0] UR_SYNC_BYTE   = 8'hA5;
  localparam int         UR_FRAME_BYTES = 8;
  localparam logic [7:0] UR_DROP_MAX    = 8'd255;

endpackage

// File: rtl/cpu_result_uart_tx_byte.sv
// One 8N1 UART byte transmitter. A start accepted in the last stop-bit cycle
// chains the next byte with no idle gap; done pulses in that same cycle.
module uart_tx_byte
  import cpu_result_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output ur_state_t  state
);

  localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  // Handshake: start is sampled only in IDLE or the final STOP cycle (done=1).
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            sh    <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= sh[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sh      <= {1'b0, sh[7:1]};
              tx      <= sh[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (start) begin
              sh    <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_result_uart.sv
// Watches the CPU result pair, buffers one snapshot and sends it as a UART frame.
// Define CPU_RESULT_UART_SYNC_EN to prefix each frame with the 0xA5 sync byte.
module cpu_result_uart
  import cpu_result_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] output1,
  input  logic [31:0] output2,
  input  logic        enable,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

`ifdef CPU_RESULT_UART_SYNC_EN
  localparam logic [3:0] LAST_IDX = 4'(UR_FRAME_BYTES);
`else
  localparam logic [3:0] LAST_IDX = 4'(UR_FRAME_BYTES - 1);
`endif

  logic [31:0] prev1, prev2;
  logic [63:0] pend;
  logic        pend_v;
  logic [63:0] frame_sh;
  logic [3:0]  byte_idx;
  logic        change, consume, more, start, done;
  logic [7:0]  data, first_byte;
  logic [63:0] first_sh;
  ur_state_t   tx_state;

  assign change  = enable && ({output1, output2} != {prev1, prev2});
  assign consume = (tx_state == IDLE) && pend_v;
  assign more    = done && (byte_idx != LAST_IDX);
  assign start   = consume || more;
  assign busy    = (tx_state != IDLE);

  // frame_sh always holds the bytes still to send, next one in [63:56].
`ifdef CPU_RESULT_UART_SYNC_EN
  assign first_byte = UR_SYNC_BYTE;
  assign first_sh   = pend;
`else
  assign first_byte = pend[63:56];
  assign first_sh   = {pend[55:0], 8'h00};
`endif
  assign data = consume ? first_byte : frame_sh[63:56];

  always_ff @(posedge clk) begin
    if (reset) begin
      prev1    <= '0;
      prev2    <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      drop_cnt <= '0;
      frame_sh <= '0;
      byte_idx <= '0;
    end else begin
      prev1 <= output1;
      prev2 <= output2;
      // A new event refills pend even while the old value is being consumed.
      if (change) begin
        pend   <= {output1, output2};
        pend_v <= 1'b1;
        if (pend_v && !consume && drop_cnt != UR_DROP_MAX)
          drop_cnt <= drop_cnt + 8'd1;
      end else if (consume) begin
        pend_v <= 1'b0;
      end
      if (consume) begin
        frame_sh <= first_sh;
        byte_idx <= '0;
      end else if (more) begin
        frame_sh <= {frame_sh[55:0], 8'h00};
        byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .tx    (tx),
    .done  (done),
    .state (tx_state)
  );

endmodule

// File: tb/tb_cpu_result_uart.sv
// Directed bench for cpu_result_uart at CLK_DIV=4: decodes tx frames and checks
// latency, coalescing, drop counting, enable gating and mid-frame reset.
module tb_cpu_result_uart;

  localparam int CLK_DIV = 4;
`ifdef CPU_RESULT_UART_SYNC_EN
  localparam int          NB  = 9;
  localparam logic [71:0] PFX = {8'hA5, 64'h0};
`else
  localparam int          NB  = 8;
  localparam logic [71:0] PFX = 72'h0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] output1, output2;
  logic        tx, busy;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [71:0] exp_q[$];

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [63:0] frame;
  } vec_t;
  vec_t vecs[4];

  cpu_result_uart #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .output1  (output1),
    .output2  (output2),
    .enable   (enable),
    .tx       (tx),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] b);
    output1 = a;
    output2 = b;
  endtask

  // Sample every bit mid-cell; returns at the first cycle after the frame.
  task automatic rx_frame(output logic [71:0] val);
    int n;
    logic [7:0] b;
    n = 0;
    val = '0;
    b = '0;
    while (tx !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("rx_start_seen", tx, 0);
    if (tx !== 1'b0) return;
    for (int i = 0; i < NB; i++) begin
      tick_n(2);
      chk("start_bit", tx, 0);
      for (int j = 0; j < 8; j++) begin
        tick_n(4);
        b[j] = tx;
      end
      tick_n(4);
      chk("stop_bit", tx, 1);
      if (i == NB - 1) chk("busy_last_stop", busy, 1);
      tick_n(2);
      val = {val[63:0], b};
    end
  endtask

  // scoreboard
  task automatic frame_vs_q(input string name);
    logic [71:0] got, expv;
    rx_frame(got);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s act=%h exp=<empty queue>", name, got);
    end else begin
      expv = exp_q.pop_front();
      checks--;
      chk(name, got, expv);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    logic [31:0] last1, last2;
    reset = 1'b1;
    enable = 1'b1;
    set_in(32'h0, 32'h0);

    // reset held 20 cycles with zero inputs
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_drop", drop_cnt, 0);
    end
    reset = 1'b0;
    tick_n(3);
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_tx", tx, 1);

    // table-driven single frames
    vecs[0] = '{32'h12345678, 32'h9ABCDEF0, 64'h123456789ABCDEF0};
    vecs[1] = '{32'h00000000, 32'h00000001, 64'h0000000000000001};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 64'hFFFFFFFF00000000};
    vecs[3] = '{32'h0000A55A, 32'h80000001, 64'h0000A55A80000001};
    for (int v = 0; v < 4; v++) begin
      set_in(vecs[v].o1, vecs[v].o2);
      tick();
      chk("pend_stage_tx", tx, 1);
      chk("pend_stage_busy", busy, 0);
      tick();
      chk("start_tx_low", tx, 0);
      chk("start_busy", busy, 1);
      exp_q.push_back(PFX | {8'h00, vecs[v].frame});
      frame_vs_q("vec_frame");
      chk("frame_end_busy", busy, 0);
      chk("frame_end_tx", tx, 1);
      chk("vec_drop", drop_cnt, 0);
      tick_n(5);
    end

    // three changes during one frame: only the last survives, two drops
    set_in(32'h11111111, 32'h22222222);
    tick_n(2);
    chk("coal_start_busy", busy, 1);
    tick_n(10);
    set_in(32'h33333333, 32'h44444444);
    tick_n(20);
    chk("coal_drop_first", drop_cnt, 0);
    set_in(32'h55555555, 32'h66666666);
    tick_n(20);
    set_in(32'h77777777, 32'h88888888);
    tick_n(2);
    chk("coal_drop", drop_cnt, 2);
    exp_q.push_back(PFX | {8'h00, 64'h7777777788888888});
    wait_idle();
    frame_vs_q("coal_frame");
    chk("coal_drop_after", drop_cnt, 2);
    tick_n(5);

    // event in the same cycle that IDLE consumes pend
    set_in(32'hAAAA0000, 32'h0000BBBB);
    tick_n(32);
    set_in(32'hC0C0C0C0, 32'h0D0D0D0D);
    tick();
    chk("sim_drop_pre", drop_cnt, 2);
    wait_idle();
    set_in(32'h01020304, 32'h05060708);
    exp_q.push_back(PFX | {8'h00, 64'hC0C0C0C00D0D0D0D});
    exp_q.push_back(PFX | {8'h00, 64'h0102030405060708});
    frame_vs_q("sim_frame_old");
    chk("sim_gap_busy", busy, 0);
    frame_vs_q("sim_frame_new");
    chk("sim_drop", drop_cnt, 2);
    tick_n(5);

    // drop counter saturation
    set_in(32'hFEEDF00D, 32'h0BADCAFE);
    tick_n(2);
    last1 = '0;
    last2 = '0;
    for (int i = 0; i < 300; i++) begin
      last1 = (i % 2 == 0) ? 32'h13572468 : 32'h24681357;
      last2 = 32'(i);
      set_in(last1, last2);
      tick();
    end
    chk("sat_drop", drop_cnt, 255);
    exp_q.push_back(PFX | {8'h00, last1, last2});
    wait_idle();
    frame_vs_q("sat_frame");
    chk("sat_drop_hold", drop_cnt, 255);
    tick_n(5);

    // enable low suppresses events; prev keeps tracking
    enable = 1'b0;
    set_in(32'hDEADBEEF, 32'hCAFEBABE);
    tick_n(30);
    chk("en_low_busy", busy, 0);
    chk("en_low_tx", tx, 1);
    enable = 1'b1;
    tick_n(10);
    chk("en_restore_busy", busy, 0);

    // reset mid-DATA, then automatic resend of the held inputs
    set_in(32'h00000001, 32'h00000002);
    tick_n(2);
    tick_n(12);
    chk("mid_data_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_drop", drop_cnt, 0);
    tick();
    chk("rst_release_tx", tx, 1);
    tick();
    chk("rst_release_start", tx, 0);
    exp_q.push_back(PFX | {8'h00, 64'h0000000100000002});
    frame_vs_q("rst_frame");
    chk("rst_frame_end_busy", busy, 0);

    chk("exp_q_drained", 72'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_result_uart.md
# cpu_result_uart

Downstream reporter for the single-cycle CPU's `output1`/`output2` result ports ($v0 and $a0).
- Detects any change in the 64-bit result pair and latches a snapshot.
- Serialises each snapshot as an 8-byte UART 8N1 frame on `tx`, so results can be read on a host terminal.
- Sits between the CPU top level and the board UART pin. It holds one pending snapshot and coalesces changes that arrive while a frame is in flight.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per UART bit; legal range ≥ 2.

Ports:
- `clk` in 1: system clock, shared with the CPU.
- `reset` in 1: synchronous, active-high; one clock; same signal that resets the CPU.
- `output1` in 32: CPU result word 1.
- `output2` in 32: CPU result word 2.
- `enable` in 1: when low, new changes are ignored; a frame in flight still completes.
- `tx` out 1: UART serial line; idle high.
- `busy` out 1: high while a frame is being transmitted.
- `drop_cnt` out 8: count of snapshots overwritten before being sent; saturates at 255.

## Operation
- Registers `prev1`/`prev2` reset to 0 and load `output1`/`output2` every cycle, regardless of `enable`.
- Change event (combinational): `enable && {output1,output2} != {prev1,prev2}`.
- Pending buffer `pend` (64 b) plus flag `pend_v`:
  - On an event, `pend` loads `{output1,output2}` and `pend_v` is set.
  - If `pend_v` was already set and is not being consumed this cycle, increment `drop_cnt`, saturating at 255.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE with `pend_v` set: copy `pend` into the 64-bit frame shift register, set byte index to 0, clear `pend_v`, go to START.
  - START: `tx=0` for `CLK_DIV` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLK_DIV` cycles, then go to STOP.
  - STOP: `tx=1` for `CLK_DIV` cycles. If byte index < 7, increment it and go to START; otherwise go to IDLE.
- Byte order: `output1[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, then `output2[31:24]` … `output2[7:0]`.
- Bytes are sent back-to-back with no idle gap. Frame length is 80·`CLK_DIV` cycles.
- `busy = (state != IDLE)`.

## Timing
- Reset values: `tx=1`, `busy=0`, `drop_cnt=0`, `pend_v=0`, `prev1=prev2=0`, state IDLE, bit counter 0.
- Latency:
  - Input change seen in cycle N → `pend_v` high in cycle N+1.
  - FSM leaves IDLE at the end of cycle N+1.
  - `tx` falls and `busy` rises in cycle N+2.
- Baud counter counts 0..`CLK_DIV`-1. A bit boundary occurs when the counter reaches `CLK_DIV`-1; the counter then wraps to 0.
- Simultaneous event and IDLE consume in the same cycle:
  - The old `pend` goes to the shifter.
  - The new value lands in `pend` with `pend_v=1`.
  - `drop_cnt` is not incremented.
- Multiple events during one frame: only the last value is kept. Each overwrite of a valid `pend` increments `drop_cnt`.
- Reset mid-frame: `tx` returns to 1 in the next cycle and all state clears. Because `prev` also clears, nonzero inputs after reset raise an event in the first cycle after reset is released.
- `enable` deassert mid-frame: the frame completes. An already-set `pend_v` is still sent.
- After the last stop bit, a pending snapshot starts its start bit in the next cycle: one IDLE cycle between frames.

## Configuration
- Macro: `CPU_RESULT_UART_SYNC_EN`.
- Defined: each frame is preceded by the sync byte 0xA5 with its own start and stop bits.
  - Frame becomes 9 bytes, 90·`CLK_DIV` cycles.
  - Byte index runs 0..8; index 0 is the sync byte.
- Undefined: 8-byte frame exactly as described above; no sync logic is synthesised.

## Structure
- Shared package `cpu_result_uart_pkg` holds:
  - FSM state enum `ur_state_t` (IDLE, START, DATA, STOP).
  - `UR_SYNC_BYTE` = 8'hA5.
  - `UR_FRAME_BYTES` = 8.
  - `UR_DROP_MAX` = 8'd255.
- One sub-module, `uart_tx_byte`:
  - Inputs: `clk`, `reset`, `start`, `data[7:0]`.
  - Outputs: `tx`, `done` (one-cycle pulse at the end of the stop bit).
  - Parameter: `CLK_DIV`.
  - The top level sequences bytes with it and owns change detection, the pending buffer and `drop_cnt`.

## Test plan
All scenarios use `CLK_DIV=4`.
- Reset with inputs 0, held 20 cycles → `tx=1`, `busy=0`, `drop_cnt=0` throughout.
- `output1`=0x12345678, `output2`=0x9ABCDEF0 in cycle N → `tx` low at N+2.
  - Decoded bytes: 12 34 56 78 9A BC DE F0.
  - `busy` falls after 320 cycles.
- Three distinct changes during one frame → the next frame carries only the third value; `drop_cnt=2`.
- Change in the same cycle the FSM consumes `pend` → both values are sent in consecutive frames; `drop_cnt` is unchanged.
- `reset` asserted mid-DATA with inputs 0x1/0x2 → `tx=1` next cycle.
  - After release, a new frame starts and decodes as 00 00 00 01 00 00 00 02.
- With `CPU_RESULT_UART_SYNC_EN` defined, input 0x0/0x1 → bytes A5 00 00 00 00 00 00 00 01; frame lasts 360 cycles.
